// File: rtl/rsa_pkg.sv
// ============================================================================
// Module      : rsa_pkg
// Description : Shared constants and FSM encoding for the RSA decrypt core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rsa_pkg;
  localparam int WIDTH      = 32;
  localparam int MUL_CYCLES = WIDTH + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_SQR   = 3'd2;
  localparam logic [2:0] S_MUL   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
endpackage

`default_nettype wire

// File: rtl/mod_mul_seq.sv
// ============================================================================
// Module      : mod_mul_seq
// Description : Sequential modular multiplier (a*b mod n), MSB-first
//               interleaved reduction; one load cycle plus WIDTH iterations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_mul_seq #(
  parameter int WIDTH = rsa_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_r;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;

  logic [WIDTH+1:0] w_n_ext;
  logic [WIDTH+1:0] w_sum;
  logic [WIDTH+1:0] w_sub1;
  logic [WIDTH-1:0] w_sub2;

  // 2R + a < 3N, so two conditional subtractions restore R < N.
  always_comb begin
    w_n_ext = {2'b00, r_n};
    w_sum   = {1'b0, r_r, 1'b0} + (r_b[WIDTH-1] ? {2'b00, r_a} : '0);
    w_sub1  = (w_sum >= w_n_ext) ? (w_sum - w_n_ext) : w_sum;
    w_sub2  = (w_sub1 >= w_n_ext) ? WIDTH'(w_sub1 - w_n_ext) : w_sub1[WIDTH-1:0];
  end

  assign done   = r_busy && (r_cnt == CW'(1));
  assign result = w_sub2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a    <= '0;
      r_b    <= '0;
      r_n    <= '0;
      r_r    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (start) begin
      r_a    <= a;
      r_b    <= b;
      r_n    <= n;
      r_r    <= '0;
      r_cnt  <= CW'(WIDTH);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_r   <= w_sub2;
      r_b   <= {r_b[WIDTH-2:0], 1'b0};
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) begin
        r_busy <= 1'b0;
      end
    end
  end
endmodule

`default_nettype wire

// File: rtl/rsa_decrypt.sv
// ============================================================================
// Module      : rsa_decrypt
// Description : Constant-time RSA decryption M = C^D mod N using left-to-right
//               square-and-always-multiply over a shared modular multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rsa_decrypt #(
  parameter int WIDTH = rsa_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cipht,
  input  logic [WIDTH-1:0] key_exp,
  input  logic [WIDTH-1:0] key_n,
  input  logic             in_vaild,
  output logic             ready,
  output logic             vaild,
  output logic [WIDTH-1:0] plaint,
  output logic             err
);
  import rsa_pkg::*;

  localparam int BW = $clog2(WIDTH);

  logic [2:0]       r_state;
  logic [WIDTH-1:0] r_c;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_acc;
  logic [BW-1:0]    r_bit;
  logic             r_start;
  logic [WIDTH-1:0] r_plaint;
  logic             r_err;

  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_res;
  logic [WIDTH-1:0] w_mul_b;

  assign w_mul_b = (r_state == S_MUL) ? r_c : r_acc;

  mod_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk    (clk),
    .reset  (reset),
    .start  (r_start),
    .a      (r_acc),
    .b      (w_mul_b),
    .n      (r_n),
    .done   (w_mul_done),
    .result (w_mul_res)
  );

  assign ready  = (r_state == S_IDLE);
  assign vaild  = (r_state == S_DONE);
  assign plaint = r_plaint;
  assign err    = r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_c      <= '0;
      r_d      <= '0;
      r_n      <= '0;
      r_acc    <= '0;
      r_bit    <= '0;
      r_start  <= 1'b0;
      r_plaint <= '0;
      r_err    <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_vaild) begin
            r_c     <= cipht;
            r_d     <= key_exp;
            r_n     <= key_n;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if ((r_n < WIDTH'(2)) || (r_c >= r_n)) begin
            r_plaint <= '0;
            r_err    <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_acc   <= WIDTH'(1);
            r_bit   <= BW'(WIDTH - 1);
            r_start <= 1'b1;
            r_state <= S_SQR;
          end
        end
        S_SQR: begin
          if (w_mul_done) begin
            r_acc   <= w_mul_res;
            r_start <= 1'b1;
            r_state <= S_MUL;
          end
        end
        S_MUL: begin
          // The product is always computed; the key bit only selects it.
          if (w_mul_done) begin
            if (r_d[r_bit]) begin
              r_acc <= w_mul_res;
            end
            if (r_bit == '0) begin
              r_plaint <= r_d[r_bit] ? w_mul_res : r_acc;
              r_err    <= 1'b0;
              r_state  <= S_DONE;
            end else begin
              r_bit   <= r_bit - BW'(1);
              r_start <= 1'b1;
              r_state <= S_SQR;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

`default_nettype wire
